// File: rtl/dispensador_vuelto.sv
// Coin payout engine: pays a change amount (units of 100) with 500 coins first, then 100 coins,
// one coin per req/ack handshake with the ejector, tracking inventory and coins paid.
module dispensador_vuelto #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned INV500_INIT = 10,
  parameter int unsigned INV100_INIT = 20,
  parameter int unsigned ACK_TIMEOUT = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] amount,
  input  logic             refill,
  input  logic             ack,
  output logic             req500,
  output logic             req100,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [WIDTH-1:0] remaining,
  output logic [WIDTH-1:0] n500,
  output logic [WIDTH-1:0] n100,
  output logic [WIDTH-1:0] inv500,
  output logic [WIDTH-1:0] inv100
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StReq500,
    StReq100,
    StWaitRel,
    StDone,
    StFault
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] n500_q, n500_d;
  logic [WIDTH-1:0] n100_q, n100_d;
  logic [WIDTH-1:0] inv500_q, inv500_d;
  logic [WIDTH-1:0] inv100_q, inv100_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      tmo_q    <= '0;
      fault_q  <= 1'b0;
      rem_q    <= '0;
      n500_q   <= '0;
      n100_q   <= '0;
      inv500_q <= WIDTH'(INV500_INIT);
      inv100_q <= WIDTH'(INV100_INIT);
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      fault_q  <= fault_d;
      rem_q    <= rem_d;
      n500_q   <= n500_d;
      n100_q   <= n100_d;
      inv500_q <= inv500_d;
      inv100_q <= inv100_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    fault_d  = fault_q;
    rem_d    = rem_q;
    n500_d   = n500_q;
    n100_d   = n100_q;
    inv500_d = inv500_q;
    inv100_d = inv100_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rem_d   = amount;
          n500_d  = '0;
          n100_d  = '0;
          fault_d = 1'b0;
          state_d = StSelect;
        end else if (refill) begin
          inv500_d = WIDTH'(INV500_INIT);
          inv100_d = WIDTH'(INV100_INIT);
        end
      end
      StSelect: begin
        tmo_d = '0;
        if (rem_q == '0) begin
          state_d = StDone;
        end else if (rem_q >= WIDTH'(5) && inv500_q != '0) begin
          state_d = StReq500;
        end else if (inv100_q != '0) begin
          state_d = StReq100;
        end else begin
          fault_d = 1'b1;
          state_d = StFault;
        end
      end
      StReq500: begin
        // SELECT already guaranteed rem_q >= 5 and stock, so these cannot wrap.
        if (ack) begin
          rem_d    = rem_q - WIDTH'(5);
          inv500_d = inv500_q - WIDTH'(1);
          n500_d   = n500_q + WIDTH'(1);
          state_d  = StWaitRel;
        end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = StFault;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StReq100: begin
        if (ack) begin
          rem_d    = rem_q - WIDTH'(1);
          inv100_d = inv100_q - WIDTH'(1);
          n100_d   = n100_q + WIDTH'(1);
          state_d  = StWaitRel;
        end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = StFault;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StWaitRel: begin
        if (!ack) state_d = StSelect;
      end
      StDone:  state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign req500    = (state_q == StReq500);
  assign req100    = (state_q == StReq100);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign fault     = fault_q;
  assign remaining = rem_q;
  assign n500      = n500_q;
  assign n100      = n100_q;
  assign inv500    = inv500_q;
  assign inv100    = inv100_q;

endmodule
